dsp_result_collector: RTL and testbench

- Result-side companion to DSP_top. It consumes DSP_top's `out` bus.
- Tracks every accepted `start` together with its mode and mac tag, then captures `out` on the exact cycle the result is valid.
- Buffers captured results in a first-word-fall-through (FWFT) FIFO with a valid/ready consumer interface.
- DSP_top cannot stall, so the collector also produces the issue-credit signal the operand driver must obey.

---
 rtl/dsp_result_collector.sv | 180 ++++++++++++++++++
 tb/tb_dsp_result_collector.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_result_collector.sv
// dsp_result_collector: follows every accepted DSP_top start, captures dsp_out on the
// cycle its result is valid, queues it in a FWFT FIFO and issues start credits.
module dsp_result_collector #(
   parameter int N          = 32,
   parameter int PIPES      = 2,
   parameter int BASE_LAT   = PIPES + 2,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic [1:0]                  mode,
   input  logic                        mac,
   input  logic [2*N-1:0]              dsp_out,
   output logic                        issue_ok,
   output logic                        res_valid,
   input  logic                        res_ready,
   output logic [2*N-1:0]              res_data,
   output logic [1:0]                  res_mode,
   output logic                        res_mac,
   output logic [$clog2(FIFO_DEPTH):0] inflight,
   output logic                        protocol_err,
   output logic                        overflow
);
   localparam int TRK_DEPTH = BASE_LAT + 3;
   localparam int TW        = $clog2(TRK_DEPTH);
   localparam int AW        = $clog2(FIFO_DEPTH);
   localparam int CW        = AW + 1;
   localparam int SW        = CW + 1;
   localparam int EW        = 2*N + 3;
   localparam int SLOT_BASE = TRK_DEPTH - BASE_LAT + 1;

   function automatic logic [1:0] win_load(input logic [1:0] m);
      logic [1:0] r;
      case (m)
         2'd1:    r = 2'd1;
         2'd2:    r = 2'd3;
         default: r = 2'd0;
      endcase
      return r;
   endfunction

   // Entry slot chosen so that the tag reaches the last stage on its capture cycle.
   function automatic logic [TW-1:0] trk_slot(input logic [1:0] m);
      logic [TW-1:0] r;
      case (m)
         2'd1:    r = TW'(SLOT_BASE - 2);
         2'd2:    r = TW'(SLOT_BASE - 4);
         default: r = TW'(SLOT_BASE - 1);
      endcase
      return r;
   endfunction

   logic [1:0]                   rst_sync_r;
   logic                         core_rst_n_s;
   logic [1:0]                   win_cnt_r;
   logic [CW-1:0]                inflight_r;
   logic                         protocol_err_r;
   logic                         overflow_r;
   logic [TRK_DEPTH-1:0]         trk_vld_r, trk_vld_s;
   logic [TRK_DEPTH-1:0][1:0]    trk_mode_r, trk_mode_s;
   logic [TRK_DEPTH-1:0]         trk_mac_r, trk_mac_s;
   logic [EW-1:0]                mem_r [FIFO_DEPTH];
   logic [AW-1:0]                wr_ptr_r, rd_ptr_r;
   logic [CW-1:0]                count_r;
   logic                         accept_s, start_bad_s, collide_s, credit_s;
   logic                         capture_s, full_s, pop_s, push_s, drop_s;
   logic [TW-1:0]                slot_s;

   // Reset synchronizer: asserts asynchronously, releases on a clock edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_sync_r <= 2'b00;
      end else begin
         rst_sync_r <= {rst_sync_r[0], 1'b1};
      end
   end
   assign core_rst_n_s = rst_sync_r[1];

   assign credit_s  = ({1'b0, count_r} + {1'b0, inflight_r}) < SW'(FIFO_DEPTH);
   assign issue_ok  = core_rst_n_s && (win_cnt_r == 2'd0) && credit_s;
   assign capture_s = trk_vld_r[TRK_DEPTH-1];
   assign res_valid = (count_r != CW'(0));
   assign full_s    = (count_r == CW'(FIFO_DEPTH));
   assign pop_s     = res_valid && res_ready;
   assign push_s    = capture_s && (!full_s || pop_s);
   assign drop_s    = capture_s && full_s && !pop_s;
   assign slot_s    = trk_slot(mode);

   assign {res_mode, res_mac, res_data} = mem_r[rd_ptr_r];
   assign inflight     = inflight_r;
   assign protocol_err = protocol_err_r;
   assign overflow     = overflow_r;

   // Accept decision and tracker advance; an insertion onto an occupied slot loses.
   always_comb begin
      accept_s    = 1'b0;
      start_bad_s = 1'b0;
      collide_s   = 1'b0;
      trk_vld_s   = {trk_vld_r[TRK_DEPTH-2:0], 1'b0};
      trk_mode_s  = {trk_mode_r[TRK_DEPTH-2:0], 2'b00};
      trk_mac_s   = {trk_mac_r[TRK_DEPTH-2:0], 1'b0};
      if (start && issue_ok && (mode != 2'd3)) begin
         accept_s = 1'b1;
      end else begin
         start_bad_s = start;
      end
      if (accept_s) begin
         if (trk_vld_s[slot_s]) begin
            collide_s = 1'b1;
         end else begin
            trk_vld_s[slot_s]  = 1'b1;
            trk_mode_s[slot_s] = mode;
            trk_mac_s[slot_s]  = mac;
         end
      end else begin
         collide_s = 1'b0;
      end
   end

   // Issue window, in-flight count, tracker and sticky error flags.
   always_ff @(posedge clk or negedge core_rst_n_s) begin
      if (!core_rst_n_s) begin
         win_cnt_r      <= 2'd0;
         inflight_r     <= {CW{1'b0}};
         protocol_err_r <= 1'b0;
         overflow_r     <= 1'b0;
         trk_vld_r      <= {TRK_DEPTH{1'b0}};
         trk_mode_r     <= {(2*TRK_DEPTH){1'b0}};
         trk_mac_r      <= {TRK_DEPTH{1'b0}};
      end else begin
         if (accept_s) begin
            win_cnt_r <= win_load(mode);
         end else if (win_cnt_r != 2'd0) begin
            win_cnt_r <= win_cnt_r - 2'd1;
         end else begin
            win_cnt_r <= win_cnt_r;
         end
         case ({accept_s, capture_s})
            2'b10:   inflight_r <= inflight_r + CW'(1);
            2'b01:   inflight_r <= inflight_r - CW'(1);
            default: inflight_r <= inflight_r;
         endcase
         protocol_err_r <= protocol_err_r | start_bad_s | collide_s;
         overflow_r     <= overflow_r | drop_s;
         trk_vld_r      <= trk_vld_s;
         trk_mode_r     <= trk_mode_s;
         trk_mac_r      <= trk_mac_s;
      end
   end

   // Result FIFO; the head entry drives the result outputs directly.
   always_ff @(posedge clk or negedge core_rst_n_s) begin
      if (!core_rst_n_s) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_r[i] <= {EW{1'b0}};
         end
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (push_s) begin
            mem_r[wr_ptr_r] <= {trk_mode_r[TRK_DEPTH-1], trk_mac_r[TRK_DEPTH-1], dsp_out};
            wr_ptr_r        <= wr_ptr_r + AW'(1);
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end
endmodule

// File: tb/tb_dsp_result_collector.sv
// Bench for dsp_result_collector: queue-based reference model checked every cycle,
// directed scenarios with hand-computed literals, then randomized traffic.
module tb_dsp_result_collector;
   localparam int N        = 32;
   localparam int DEPTH    = 8;
   localparam int BASE_LAT = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  mode = 2'd0;
   logic        mac = 1'b0;
   logic [63:0] dsp_out = 64'd0;
   logic        res_ready = 1'b0;
   logic        issue_ok, res_valid, res_mac, protocol_err, overflow;
   logic [63:0] res_data;
   logic [1:0]  res_mode;
   logic [3:0]  inflight;

   dsp_result_collector #(.N(N), .PIPES(2), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .mac(mac),
      .dsp_out(dsp_out), .issue_ok(issue_ok), .res_valid(res_valid),
      .res_ready(res_ready), .res_data(res_data), .res_mode(res_mode),
      .res_mac(res_mac), .inflight(inflight), .protocol_err(protocol_err),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;
   logic rnd_data = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct { int cap; logic [1:0] mode; logic mac; } pend_t;
   typedef struct { logic [63:0] data; logic [1:0] mode; logic mac; } ent_t;
   pend_t pend_q[$];
   ent_t  exp_q[$];
   int    reopen = 0;
   int    rel = 0;
   logic  m_perr = 1'b0, m_ovf = 1'b0;
   int    m_fc, m_inf;
   logic  m_ok, m_pop, m_cap, m_acc;
   pend_t m_p;
   ent_t  m_e;

   function automatic int issue_cycles(input logic [1:0] m);
      return (m == 2'd2) ? 4 : (m == 2'd1) ? 2 : 1;
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         pend_q.delete();
         exp_q.delete();
         reopen = 0; m_perr = 1'b0; m_ovf = 1'b0; rel = 0;
         chk("rst_issue_ok", issue_ok, 1'b0);
         chk("rst_res_valid", res_valid, 1'b0);
         chk("rst_res_data", res_data, 64'd0);
         chk("rst_res_mode", res_mode, 2'd0);
         chk("rst_res_mac", res_mac, 1'b0);
         chk("rst_inflight", inflight, 4'd0);
         chk("rst_protocol_err", protocol_err, 1'b0);
         chk("rst_overflow", overflow, 1'b0);
      end else if (rel < 4) begin
         rel++;
      end else begin
         m_fc = exp_q.size();
         m_inf = pend_q.size();
         m_ok = (cyc >= reopen) && (m_fc + m_inf < DEPTH);
         chk("issue_ok", issue_ok, m_ok);
         chk("res_valid", res_valid, m_fc != 0);
         chk("inflight", inflight, 64'(m_inf));
         chk("protocol_err", protocol_err, m_perr);
         chk("overflow", overflow, m_ovf);
         if (m_fc != 0) begin
            chk("res_data", res_data, exp_q[0].data);
            chk("res_mode", res_mode, exp_q[0].mode);
            chk("res_mac", res_mac, exp_q[0].mac);
         end
         m_pop = (m_fc != 0) && res_ready;
         m_cap = (m_inf != 0) && (pend_q[0].cap == cyc);
         m_acc = start && m_ok && (mode != 2'd3);
         if (start && !m_acc) m_perr = 1'b1;
         if (m_pop) void'(exp_q.pop_front());
         if (m_cap) begin
            m_p = pend_q.pop_front();
            if ((m_fc < DEPTH) || m_pop) begin
               m_e.data = dsp_out; m_e.mode = m_p.mode; m_e.mac = m_p.mac;
               exp_q.push_back(m_e);
            end else begin
               m_ovf = 1'b1;
            end
         end
         if (m_acc) begin
            m_p.cap = cyc + BASE_LAT + issue_cycles(mode) - 1;
            m_p.mode = mode; m_p.mac = mac;
            pend_q.push_back(m_p);
            reopen = cyc + issue_cycles(mode);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input logic s, input logic [1:0] m, input logic mc, input logic rdy);
      @(posedge clk); #1;
      start = s; mode = m; mac = mc; res_ready = rdy;
      dsp_out = rnd_data ? {$urandom, $urandom} : 64'(cyc);
      @(negedge clk);
   endtask

   task automatic tick_rand(input int ready_pct);
      logic ok;
      int r;
      @(posedge clk); #1;
      ok = issue_ok;
      start = ($urandom_range(0, 3) != 0) && (ok || ($urandom_range(0, 15) == 0));
      r = $urandom_range(0, 15);
      mode = (r == 0) ? 2'd3 : 2'(r % 3);
      mac = 1'($urandom_range(0, 1));
      res_ready = ($urandom_range(0, 99) < ready_pct);
      dsp_out = {$urandom, $urandom};
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0; start = 1'b0; res_ready = 1'b0;
      @(negedge clk);
      chk("reset_now_issue_ok", issue_ok, 1'b0);
      chk("reset_now_valid", res_valid, 1'b0);
      chk("reset_now_inflight", inflight, 4'd0);
      repeat (2) tick(1'b0, 2'd0, 1'b0, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (6) tick(1'b0, 2'd0, 1'b0, 1'b0);
   endtask

   int b;
   int hit;
   int mix_vis[4]        = '{5, 7, 11, 12};
   int mix_dat[4]        = '{4, 6, 10, 11};
   logic [1:0] mix_md[4] = '{2'd0, 2'd1, 2'd2, 2'd0};
   logic mix_mc[4]       = '{1'b0, 1'b1, 1'b0, 1'b0};

   initial begin
      #2 rst_n = 1'b0;
      do_reset();

      // mode-0 back-to-back stream
      for (int i = 0; i < 4; i++) begin
         tick(1'b1, 2'd0, 1'b0, 1'b1);
         if (i == 0) b = cyc;
         chk("m0_issue_ok", issue_ok, 1'b1);
      end
      for (int i = 4; i <= 9; i++) begin
         tick(1'b0, 2'd0, 1'b0, 1'b1);
         if ((i >= 5) && (i <= 8)) begin
            chk("m0_valid", res_valid, 1'b1);
            chk("m0_data", res_data, 64'(b + i - 1));
         end else begin
            chk("m0_idle", res_valid, 1'b0);
         end
      end

      // mode-2 spacing with an early start
      tick(1'b1, 2'd2, 1'b0, 1'b1);
      b = cyc;
      chk("m2_issue_ok", issue_ok, 1'b1);
      chk("m2_perr_before", protocol_err, 1'b0);
      tick(1'b0, 2'd0, 1'b0, 1'b1);
      chk("m2_closed1", issue_ok, 1'b0);
      tick(1'b1, 2'd0, 1'b0, 1'b1);
      chk("m2_closed2", issue_ok, 1'b0);
      tick(1'b0, 2'd0, 1'b0, 1'b1);
      chk("m2_closed3", issue_ok, 1'b0);
      chk("m2_perr", protocol_err, 1'b1);
      tick(1'b0, 2'd0, 1'b0, 1'b1);
      chk("m2_reopen", issue_ok, 1'b1);
      for (int i = 5; i <= 9; i++) begin
         tick(1'b0, 2'd0, 1'b0, 1'b1);
         if (i == 8) begin
            chk("m2_valid", res_valid, 1'b1);
            chk("m2_mode", res_mode, 2'd2);
            chk("m2_data", res_data, 64'(b + 7));
         end else begin
            chk("m2_idle", res_valid, 1'b0);
         end
      end

      // credit backpressure
      do_reset();
      for (int i = 0; i < 10; i++) begin
         tick(1'b1, 2'd0, 1'b0, 1'b0);
         if (i == 0) b = cyc;
         chk("cr_issue_ok", issue_ok, i < 8);
         if (i == 8) chk("cr_perr_clear", protocol_err, 1'b0);
         if (i == 9) chk("cr_perr_set", protocol_err, 1'b1);
      end
      repeat (4) tick(1'b0, 2'd0, 1'b0, 1'b0);
      chk("cr_full_valid", res_valid, 1'b1);
      chk("cr_full_inflight", inflight, 4'd0);
      chk("cr_full_issue_ok", issue_ok, 1'b0);
      chk("cr_full_overflow", overflow, 1'b0);
      for (int i = 0; i < 8; i++) begin
         tick(1'b0, 2'd0, 1'b0, 1'b1);
         chk("cr_drain_valid", res_valid, 1'b1);
         chk("cr_drain_data", res_data, 64'(b + 4 + i));
      end
      tick(1'b0, 2'd0, 1'b0, 1'b1);
      chk("cr_empty", res_valid, 1'b0);
      chk("cr_issue_back", issue_ok, 1'b1);

      // capture coinciding with a pop at the credit limit
      for (int i = 0; i < 8; i++) begin
         tick(1'b1, 2'd0, 1'b0, 1'b0);
         if (i == 0) b = cyc;
         chk("fp_issue_ok", issue_ok, 1'b1);
      end
      repeat (3) tick(1'b0, 2'd0, 1'b0, 1'b0);
      tick(1'b0, 2'd0, 1'b0, 1'b1);
      chk("fp_head", res_data, 64'(b + 4));
      chk("fp_inflight", inflight, 4'd1);
      tick(1'b0, 2'd0, 1'b0, 1'b0);
      chk("fp_next_head", res_data, 64'(b + 5));
      chk("fp_inflight_done", inflight, 4'd0);
      chk("fp_overflow", overflow, 1'b0);
      for (int i = 0; i < 7; i++) begin
         tick(1'b0, 2'd0, 1'b0, 1'b1);
         chk("fp_drain_data", res_data, 64'(b + 5 + i));
      end
      tick(1'b0, 2'd0, 1'b0, 1'b1);
      chk("fp_empty", res_valid, 1'b0);

      // mixed modes at minimum spacing
      for (int i = 0; i < 14; i++) begin
         tick((i == 0) || (i == 1) || (i == 3) || (i == 7),
              (i == 1) ? 2'd1 : ((i == 3) ? 2'd2 : 2'd0), i == 1, 1'b1);
         if (i == 0) b = cyc;
         if ((i == 0) || (i == 1) || (i == 3) || (i == 7)) chk("mix_issue_ok", issue_ok, 1'b1);
         else if ((i == 2) || ((i >= 4) && (i <= 6))) chk("mix_closed", issue_ok, 1'b0);
         hit = -1;
         for (int k = 0; k < 4; k++) if (mix_vis[k] == i) hit = k;
         if (hit >= 0) begin
            chk("mix_valid", res_valid, 1'b1);
            chk("mix_mode", res_mode, mix_md[hit]);
            chk("mix_mac", res_mac, mix_mc[hit]);
            chk("mix_data", res_data, 64'(b + mix_dat[hit]));
         end else if (i >= 4) begin
            chk("mix_idle", res_valid, 1'b0);
         end
      end

      // reset with work in flight and queued
      for (int i = 0; i < 5; i++) tick(1'b1, 2'd0, 1'b0, 1'b0);
      tick(1'b0, 2'd0, 1'b0, 1'b0);
      chk("mf_inflight", inflight, 4'd4);
      chk("mf_valid", res_valid, 1'b1);
      do_reset();
      for (int i = 0; i < 12; i++) begin
         tick(1'b0, 2'd0, 1'b0, 1'b1);
         chk("mf_no_capture", res_valid, 1'b0);
         chk("mf_inflight_zero", inflight, 4'd0);
      end
      tick(1'b1, 2'd3, 1'b0, 1'b1);
      chk("mf_m3_issue_ok", issue_ok, 1'b1);
      tick(1'b0, 2'd0, 1'b0, 1'b1);
      chk("mf_m3_perr", protocol_err, 1'b1);
      chk("mf_m3_overflow", overflow, 1'b0);
      chk("mf_m3_inflight", inflight, 4'd0);
      chk("mf_m3_valid", res_valid, 1'b0);
      chk("mf_m3_issue_after", issue_ok, 1'b1);

      // randomized traffic with varying consumer throughput
      rnd_data = 1'b1;
      for (int blk = 0; blk < 15; blk++) begin
         for (int i = 0; i < 200; i++) tick_rand((blk % 5 == 0) ? 100 :
                                                 (blk % 5 == 1) ? 50 :
                                                 (blk % 5 == 2) ? 10 :
                                                 (blk % 5 == 3) ? 0 : 80);
      end
      repeat (20) tick(1'b0, 2'd0, 1'b0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
